// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-scoreboard definitions: latency defaults,
// opcode enum and decode helpers for source-register usage.
package hazard_scoreboard_pkg;

  localparam int NREGS_DEF          = 32;
  localparam int LOAD_LAT_DEF       = 2;
  localparam int ALU_LAT_DEF        = 0;
  localparam int BRANCH_PENALTY_DEF = 2;
  localparam int CNT_W_DEF          = 32;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OPIMM  = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6f,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  function automatic logic needs_rs2(
    input logic [6:0] opc
  );
    return opc inside {OPC_STORE, OPC_OP, OPC_BRANCH};
  endfunction

  function automatic logic needs_rs1(
    input logic [6:0] opc
  );
    return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic is_ctrl(
    input logic [6:0] opc
  );
    return opc inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Countdown width; never below one bit.
  function automatic int lat_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Saturating down-counter: loads max(remaining-1, ld_val),
// synchronous clear has priority over everything.
module hazard_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         nz
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] dec;

  always_comb begin
    dec   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    cnt_d = dec;
    if (ld && (ld_val > dec)) begin
      cnt_d = ld_val;
    end
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side RAW/control hazard scoreboard with per-register
// countdowns, branch shadow and a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS          = NREGS_DEF,
  parameter int LOAD_LAT       = LOAD_LAT_DEF,
  parameter int ALU_LAT        = ALU_LAT_DEF,
  parameter int BRANCH_PENALTY = BRANCH_PENALTY_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  localparam int RW = $clog2(NREGS),
  localparam int LW = lat_width(
    max3(LOAD_LAT, ALU_LAT, BRANCH_PENALTY))
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [RW-1:0]    issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_rd_wr,
  input  logic             issue_load,
  input  logic             issue_ctrl,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic          fire;
  logic          wr_fire;
  logic          ctrl_fire;
  logic [LW-1:0] lat;
  logic          shadow_nz;

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  always_comb begin
    stall = issue_valid &
      ((issue_rs1_used & busy[issue_rs1]) |
       (issue_rs2_used & busy[issue_rs2]));
    bubble      = shadow_nz;
    issue_ready = !stall && !bubble;
    fire        = issue_valid && issue_ready;
    wr_fire     = fire && issue_rd_wr &&
                  (issue_rd != '0);
    ctrl_fire   = fire && issue_ctrl;
    lat = issue_load ? LW'(LOAD_LAT)
                     : LW'(ALU_LAT);
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    hazard_counter #(
      .W(LW)
    ) u_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .clr   (flush),
      .ld    (wr_fire && (issue_rd == RW'(r))),
      .ld_val(lat),
      .nz    (busy[r])
    );
  end

  hazard_counter #(
    .W(LW)
  ) u_shadow (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (flush),
    .ld    (ctrl_fire),
    .ld_val(LW'(BRANCH_PENALTY)),
    .nz    (shadow_nz)
  );

  // Counts stalls even on a flush cycle; flush never clears it.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised scoreboard bench: an absolute-time ready model
// predicts each cycle's outputs; a negedge monitor compares.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int LLAT  = 2;
  localparam int ALAT  = 0;
  localparam int PEN   = 2;
  localparam int CW    = 4;
  localparam int SMAX  = 15;

  logic             aclk;
  logic             aresetn;
  logic             issue_valid;
  logic             issue_ready;
  logic [RW-1:0]    issue_rs1;
  logic             issue_rs1_used;
  logic [RW-1:0]    issue_rs2;
  logic             issue_rs2_used;
  logic [RW-1:0]    issue_rd;
  logic             issue_rd_wr;
  logic             issue_load;
  logic             issue_ctrl;
  logic             flush;
  logic             stall;
  logic             bubble;
  logic [NREGS-1:0] busy;
  logic [CW-1:0]    stall_cycles;

  hazard_scoreboard #(
    .NREGS         (NREGS),
    .LOAD_LAT      (LLAT),
    .ALU_LAT       (ALAT),
    .BRANCH_PENALTY(PEN),
    .CNT_W         (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1     (issue_rs1),
    .issue_rs1_used(issue_rs1_used),
    .issue_rs2     (issue_rs2),
    .issue_rs2_used(issue_rs2_used),
    .issue_rd      (issue_rd),
    .issue_rd_wr   (issue_rd_wr),
    .issue_load    (issue_load),
    .issue_ctrl    (issue_ctrl),
    .flush         (flush),
    .stall         (stall),
    .bubble        (bubble),
    .busy          (busy),
    .stall_cycles  (stall_cycles)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic             stall;
    logic             bubble;
    logic             ready;
    logic [NREGS-1:0] busy;
    logic [CW-1:0]    sc;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Model: absolute cycle from which each register is readable.
  int now;
  int ready_at [NREGS];
  int shadow_end;
  int sc;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    now        = 0;
    shadow_end = 0;
    sc         = 0;
    for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
  endtask

  function automatic logic m_busy(input int r);
    return (r != 0) && (now < ready_at[r]);
  endfunction

  always @(negedge aclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", 64'(stall), 64'(e.stall));
      chk("bubble", 64'(bubble), 64'(e.bubble));
      chk("issue_ready", 64'(issue_ready), 64'(e.ready));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("stall_cycles", 64'(stall_cycles), 64'(e.sc));
    end
  end

  task automatic step(input logic v,
                      input int rs1, input logic u1,
                      input int rs2, input logic u2,
                      input int rd, input logic wr,
                      input logic ld, input logic ctl,
                      input logic fl);
    exp_t e;
    logic fire;
    int   lat;
    issue_valid    = v;
    issue_rs1      = RW'(rs1);
    issue_rs1_used = u1;
    issue_rs2      = RW'(rs2);
    issue_rs2_used = u2;
    issue_rd       = RW'(rd);
    issue_rd_wr    = wr;
    issue_load     = ld;
    issue_ctrl     = ctl;
    flush          = fl;
    e.stall  = v && ((u1 && m_busy(rs1)) ||
                     (u2 && m_busy(rs2)));
    e.bubble = (now < shadow_end);
    e.ready  = !e.stall && !e.bubble;
    for (int r = 0; r < NREGS; r++) e.busy[r] = m_busy(r);
    e.sc = CW'(sc);
    exp_q.push_back(e);
    fire = v && e.ready;
    @(posedge aclk);
    if (e.stall && sc < SMAX) sc++;
    if (fl) begin
      for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
      shadow_end = 0;
    end else begin
      if (fire && wr && rd != 0) begin
        lat = ld ? LLAT : ALAT;
        if (now + lat + 1 > ready_at[rd])
          ready_at[rd] = now + lat + 1;
      end
      if (fire && ctl) shadow_end = now + PEN + 1;
    end
    now++;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    issue_valid    = 1'b1;
    issue_rs1      = RW'(5);
    issue_rs1_used = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_bubble", 64'(bubble), 64'(0));
    chk("rst_ready", 64'(issue_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sc", 64'(stall_cycles), 64'(0));
    model_reset();
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    model_reset();
    aresetn        = 1'b0;
    issue_valid    = 1'b1;
    issue_rs1      = RW'(5);
    issue_rs1_used = 1'b1;
    issue_rs2      = '0;
    issue_rs2_used = 1'b0;
    issue_rd       = '0;
    issue_rd_wr    = 1'b0;
    issue_load     = 1'b0;
    issue_ctrl     = 1'b0;
    flush          = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("init_stall", 64'(stall), 64'(0));
    chk("init_bubble", 64'(bubble), 64'(0));
    chk("init_ready", 64'(issue_ready), 64'(1));
    chk("init_busy", 64'(busy), 64'(0));
    chk("init_sc", 64'(stall_cycles), 64'(0));
    aresetn = 1'b1;

    // load-use: two stall cycles, add fires on the third
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    repeat (3) step(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    chk("loaduse_sc", 64'(stall_cycles), 64'(2));
    step(1, 0, 0, 4, 1, 5, 1, 0, 0, 0);
    idle();

    // WAW: the load's longer remaining time wins
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    chk("waw_busy7", 64'(busy[7]), 64'(1));
    repeat (2) step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    idle();

    // branch shadow, then a branch reloads it
    step(1, 1, 1, 2, 1, 0, 0, 0, 1, 0);
    chk("br_bubble", 64'(bubble), 64'(1));
    chk("br_ready", 64'(issue_ready), 64'(0));
    repeat (3) step(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) idle();

    // flush squashes pending load and same-cycle issue
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    chk("flush_busy", 64'(busy), 64'(0));
    step(1, 9, 1, 10, 1, 11, 1, 0, 0, 0);
    idle();

    // x0 destination never marked
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("x0_busy", 64'(busy), 64'(0));
    step(1, 0, 1, 0, 1, 12, 1, 0, 0, 0);
    idle();

    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      int p;
      p = int'($urandom_range(0, 99));
      step(($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), 1'($urandom),
           int'($urandom_range(0, 7)), 1'($urandom),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) == 0),
           (p < 4));
    end
    idle();
    chk("sat_sc", 64'(stall_cycles), 64'(SMAX));
    @(negedge aclk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's single-stage hazard detector.
- Sits beside decode. Tracks every in-flight register write with a per-register countdown scoreboard.
- Raises a stall for RAW hazards of arbitrary producer latency and inserts a configurable number of bubbles after control-flow instructions.
- Whole-pipeline flush is supported. Exports a saturating stall-cycle counter for performance monitoring.

Parameters:
- NREGS, 32, number of architectural registers (x0 hardwired zero).
- LOAD_LAT, 2, cycles after issue until a load result is forwardable to decode.
- ALU_LAT, 0, cycles after issue until an ALU result is forwardable (0 = full forwarding).
- BRANCH_PENALTY, 2, bubbles inserted after a jump/branch issues.
- CNT_W, 32, width of the performance stall counter.
- Derived locals:
  - RW = $clog2(NREGS)
  - LW = $clog2(max(LOAD_LAT, ALU_LAT, BRANCH_PENALTY) + 1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  high when the instruction may issue this cycle
- issue_rs1  in  RW  source register 1
- issue_rs1_used  in  1  rs1 is read
- issue_rs2  in  RW  source register 2
- issue_rs2_used  in  1  rs2 is read
- issue_rd  in  RW  destination register
- issue_rd_wr  in  1  instruction writes rd
- issue_load  in  1  instruction is a load
- issue_ctrl  in  1  instruction is JAL/JALR/BRANCH
- flush  in  1  squash all in-flight instructions (trap/redirect)
- stall  out  1  RAW hazard holds decode
- bubble  out  1  control-flow shadow active; fetch must inject NOPs
- busy  out  NREGS  per-register pending-write flag (count != 0)
- stall_cycles  out  CNT_W  saturating count of cycles with stall high

Behaviour:
- State:
  - cnt[r] (LW bits) for r = 1..NREGS-1; cnt[0] is constant 0.
  - shadow (LW bits).
  - stall_cycles.
- Reset (aresetn low, asynchronous): all cnt = 0, shadow = 0, stall_cycles = 0. Hence stall = 0, bubble = 0, busy = 0, issue_ready = 1.
- Hazard (combinational, from current registered state):
  - stall = issue_valid & ((issue_rs1_used & cnt[issue_rs1] != 0) | (issue_rs2_used & cnt[issue_rs2] != 0)).
  - x0 sources never stall.
- bubble = (shadow != 0).
- issue_ready = !stall & !bubble.
- fire = issue_valid & issue_ready.
- Per-cycle update, in priority order:
  1. flush: all cnt = 0 and shadow = 0 next cycle. A same-cycle fire is ignored. stall_cycles still counts this cycle's stall.
  2. Otherwise every nonzero cnt decrements by 1 and a nonzero shadow decrements by 1.
  3. If fire & issue_rd_wr & issue_rd != 0, lat = issue_load ? LOAD_LAT : ALU_LAT, and cnt[issue_rd] <= max(cnt[issue_rd] - 1 saturating at 0, lat). On a WAW hit the longer remaining time wins.
  4. If fire & issue_ctrl: shadow <= BRANCH_PENALTY.
- Self-dependence (rd == rs): the hazard check uses pre-update state, so the instruction is not blocked by its own write.
- Latency:
  - A consumer issued k cycles after its producer passes when k > lat.
  - With LOAD_LAT=2, a load followed immediately by a dependent instruction gives exactly 2 stall cycles.
  - lat = 0 never stalls.
- While stall or bubble is high, the scoreboard keeps counting down (the downstream pipeline never stalls).
- stall_cycles increments on each cycle with stall = 1 and saturates at all-ones. It is not cleared by flush.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion operates normally.

Decomposition:
- Package core (existing) gains:
  - the latency/penalty localparam defaults;
  - helper function needs_rs2(opcode), so decode derives issue_rs*_used from the opcode.
- Sub-module hazard_counter: one saturating down-counter with load-max input and sync clear. Instantiated NREGS-1 times via generate, plus once for shadow.
- The top level holds the compare/mux logic and stall_cycles.

Test Plan:
- Reset: hold aresetn low with issue_valid=1, rs1=5 -> stall=0, bubble=0, busy=0, stall_cycles=0.
- Load-use: issue load rd=3, then add rs1=3 next cycle -> stall high 2 cycles, add fires on 3rd cycle, stall_cycles=2. With ALU_LAT=0, add rd=4 then sub rs2=4 -> no stall.
- WAW: load rd=7 (cnt=2), next cycle ALU rd=7 -> cnt[7] stays 1 (not 0). Dependent on rs1=7 stalls 1 cycle.
- Branch shadow: issue BRANCH -> bubble=1 for exactly 2 cycles and issue_ready=0 during them. A fire with issue_ctrl after the shadow reloads shadow to 2.
- Flush: load rd=9 then flush on the next cycle while an ALU rd=10 is presented -> busy=0 next cycle, rd=10 not marked, dependent on x9 issues without stall.
- x0 and saturation: load rd=0 -> busy[0]=0, reader of x0 never stalls. Force stall_cycles near all-ones (CNT_W=4) with continuous stall -> holds at 15.
